// File: rtl/dac_i2s_pkg.sv
// Shared types and limits for the I2S / left-justified DAC serial transmitter.
package dac_i2s_pkg;
  typedef enum logic {FMT_I2S, FMT_LJ} fmt_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} tx_state_t;
  localparam int MAX_SLOT = 32;
  localparam int IDX_W    = $clog2(2 * MAX_SLOT);
endpackage

// File: rtl/dac_i2s_tx_sample_fifo.sv
// Stereo-pair sample FIFO: registered level, push refused when full, pop refused when empty.
module sample_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end
endmodule

// File: rtl/dac_i2s_tx.sv
// Stereo DAC serialiser (I2S or left-justified) fed by a sample FIFO, one pair per frame.
// Define DAC_I2S_TX_ZERO_ON_UNDERRUN_EN to send silence on underrun instead of repeating the last pair.
module dac_i2s_tx
  import dac_i2s_pkg::*;
#(
  parameter int   WIDTH      = 24,
  parameter int   SLOT       = 32,
  parameter int   BCLK_DIV   = 1,
  parameter int   FIFO_DEPTH = 4,
  parameter fmt_t MODE       = FMT_I2S
) (
  input  logic                          MCLK,
  input  logic                          RESET_N,
  input  logic                          ENABLE,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [WIDTH-1:0]              IN_LEFT,
  input  logic [WIDTH-1:0]              IN_RIGHT,
  output logic                          BCLK,
  output logic                          DACLRC,
  output logic                          DACDAT,
  output logic                          UNDERRUN,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);
  localparam int                PW        = 2 * WIDTH;
  localparam int                DIV_W     = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(2 * SLOT - 1);
  localparam logic [IDX_W-1:0]  IDX_RIGHT = IDX_W'(SLOT);

  tx_state_t        r_state;
  logic [DIV_W-1:0] r_div;
  logic [IDX_W-1:0] r_idx;
  logic             r_bclk;
  logic             r_lrc;
  logic             r_dat;
  logic             r_underrun;
  logic [PW-1:0]    r_shadow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_fall;
  logic             w_start;
  logic             w_stop_done;
  logic             w_bit;
  logic [PW-1:0]    w_head;
  logic [PW-1:0]    w_fill;
  logic [PW-1:0]    w_pair;
  logic [IDX_W-1:0] w_next_idx;

  // Serial bit for frame position idx; pair is {left, right}.
  function automatic logic bit_at(input logic [IDX_W-1:0] idx, input logic [PW-1:0] pair);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] sh;
    int               k;
    k  = int'(idx);
    s  = pair[PW-1:WIDTH];
    sh = '0;
    if (k >= SLOT) begin
      k = k - SLOT;
      s = pair[WIDTH-1:0];
    end
    if (MODE == FMT_LJ) begin
      if (k < WIDTH) sh = s << k;
    end else if (k >= 1 && k <= WIDTH) begin
      sh = s << (k - 1);
    end
    return sh[WIDTH-1];
  endfunction

  sample_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (MCLK),
    .i_rst_n (RESET_N),
    .i_push  (w_push),
    .i_din   ({IN_LEFT, IN_RIGHT}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (FIFO_LEVEL)
  );

`ifdef DAC_I2S_TX_ZERO_ON_UNDERRUN_EN
  assign w_fill = '0;
`else
  assign w_fill = r_shadow;
`endif

  assign IN_READY    = !w_full;
  assign w_push      = IN_VALID && !w_full;
  assign w_fall      = (r_state != S_IDLE) && r_bclk && (r_div == DIV_LAST);
  // A new frame starts from idle, or back-to-back when the last bit ends with ENABLE still high.
  assign w_start     = ((r_state == S_IDLE) && ENABLE) || (w_fall && (r_idx == IDX_LAST) && ENABLE);
  assign w_stop_done = w_fall && (r_idx == IDX_LAST) && !ENABLE;
  assign w_pop       = w_start && !w_empty;
  assign w_pair      = w_start ? (w_empty ? w_fill : w_head) : r_shadow;
  assign w_next_idx  = w_start ? '0 : r_idx + 1'b1;
  assign w_bit       = bit_at(w_next_idx, w_pair);

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_idx      <= '0;
      r_bclk     <= 1'b0;
      r_lrc      <= 1'b0;
      r_dat      <= 1'b0;
      r_underrun <= 1'b0;
      r_shadow   <= '0;
    end else begin
      r_underrun <= w_start && w_empty;

      if (w_stop_done)                         r_state <= S_IDLE;
      else if (r_state != S_IDLE || ENABLE)    r_state <= ENABLE ? S_RUN : S_STOP;

      if (r_state == S_IDLE || w_start || w_stop_done) begin
        r_div  <= '0;
        r_bclk <= 1'b0;
      end else if (r_div == DIV_LAST) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div  <= r_div + 1'b1;
      end

      // Data and word-select move only together with the BCLK falling edge.
      if (w_stop_done) begin
        r_idx <= '0;
        r_lrc <= 1'b0;
        r_dat <= 1'b0;
      end else if (w_start || w_fall) begin
        r_idx <= w_next_idx;
        r_lrc <= (w_next_idx >= IDX_RIGHT);
        r_dat <= w_bit;
      end

      if (w_start) r_shadow <= w_pair;
    end
  end

  assign BCLK     = r_bclk;
  assign DACLRC   = r_lrc;
  assign DACDAT   = r_dat;
  assign UNDERRUN = r_underrun;
endmodule
